// File: rtl/fft_bf_sched.sv
// fft_bf_sched
//   Sequencing controller for the combinational radix-4 butterfly of the
//   16-point FFT core. It owns a 16-entry complex sample bank and loads 16
//   samples over a valid/ready stream. It then runs the 8 butterflies
//   (2 stages x 4) in place, and streams X[0..15] out in natural order.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   start                 begin a transform (honoured only in IDLE)
//   in_valid/in_ready     input stream, in_data = {Re,Im}, x[0]..x[15]
//   bf_calc_in            operands to butterfly {in4,in3,in2,in1}
//   bf_rotation           butterfly number 0..7
//   bf_calc_out           butterfly results {out4,out3,out2,out1}
//   out_valid/out_ready   output stream, out_data = X[out_index]
//   busy                  high outside IDLE
//   done                  one-cycle pulse after X[15] is accepted
//
// Build option
//   BF_PIPE_EN  registers bf_calc_in/bf_rotation. Each butterfly then takes
//               2 cycles, and CALC lasts 16 cycles.

module fft_bf_sched #(
  parameter int DW  = 17,
  parameter int NPT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] in_data,
  output logic [8*DW-1:0] bf_calc_in,
  output logic [2:0]      bf_rotation,
  input  logic [8*DW-1:0] bf_calc_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] out_data,
  output logic [3:0]      out_index,
  output logic            busy,
  output logic            done
);

  if (NPT != 16) begin : g_bad_npt
    $error("fft_bf_sched supports only NPT = 16");
  end

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_CALC   = 2'd2;
  localparam logic [1:0] ST_UNLOAD = 2'd3;

  logic [1:0]      state;
  logic [3:0]      ld_cnt;
  logic [2:0]      bf_cnt;
  logic [3:0]      out_cnt;
  logic [2*DW-1:0] bank [16];

  logic            in_fire;
  logic            out_fire;
  logic            wb_en;
  logic [3:0]      op_addr [4];
  logic [3:0]      wb_addr [4];
  logic [8*DW-1:0] bank_ops;

  assign in_ready  = (state == ST_LOAD);
  assign out_valid = (state == ST_UNLOAD);
  assign busy      = (state != ST_IDLE);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Stage 1 (bf_cnt 0..3) uses stride 4: n, n+4, n+8, n+12.
  // Stage 2 (bf_cnt 4..7) uses contiguous groups: 4m .. 4m+3.
  always_comb begin
    for (int unsigned j = 0; j < 4; j++) begin
      op_addr[j] = bf_cnt[2] ? {bf_cnt[1:0], j[1:0]} : {j[1:0], bf_cnt[1:0]};
    end
  end

  always_comb begin
    bank_ops = '0;
    for (int unsigned j = 0; j < 4; j++) begin
      bank_ops[j*2*DW +: 2*DW] = bank[op_addr[j]];
    end
  end

`ifdef BF_PIPE_EN
  // Phase 0 captures the operands and their addresses.
  // Phase 1 writes the butterfly result back to the captured addresses.
  logic            phase;
  logic [8*DW-1:0] calc_in_q;
  logic [2:0]      rot_q;
  logic [3:0]      addr_q [4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase     <= 1'b0;
      calc_in_q <= '0;
      rot_q     <= '0;
    end else if (state == ST_CALC) begin
      phase <= ~phase;
      if (!phase) begin
        calc_in_q <= bank_ops;
        rot_q     <= bf_cnt;
      end
    end else begin
      phase <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_CALC && !phase) begin
      for (int unsigned j = 0; j < 4; j++) addr_q[j] <= op_addr[j];
    end
  end

  assign wb_en       = (state == ST_CALC) && phase;
  assign bf_calc_in  = calc_in_q;
  assign bf_rotation = rot_q;

  always_comb begin
    for (int unsigned j = 0; j < 4; j++) wb_addr[j] = addr_q[j];
  end
`else
  assign wb_en       = (state == ST_CALC);
  assign bf_calc_in  = (state == ST_CALC) ? bank_ops : '0;
  assign bf_rotation = (state == ST_CALC) ? bf_cnt : '0;

  always_comb begin
    for (int unsigned j = 0; j < 4; j++) wb_addr[j] = op_addr[j];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ld_cnt  <= '0;
      bf_cnt  <= '0;
      out_cnt <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) state <= ST_LOAD;
        ST_LOAD: if (in_fire) begin
          ld_cnt <= ld_cnt + 4'd1;        // wraps to 0 after x[15]
          if (ld_cnt == 4'd15) state <= ST_CALC;
        end
        ST_CALC: if (wb_en) begin
          bf_cnt <= bf_cnt + 3'd1;        // wraps to 0 after butterfly 7
          if (bf_cnt == 3'd7) state <= ST_UNLOAD;
        end
        default: if (out_fire) begin
          out_cnt <= out_cnt + 4'd1;
          if (out_cnt == 4'd15) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

  // Sample bank: loading and write-back never occur in the same state.
  always_ff @(posedge clk) begin
    if (in_fire) bank[ld_cnt] <= in_data;
    if (wb_en) begin
      for (int unsigned j = 0; j < 4; j++) begin
        bank[wb_addr[j]] <= bf_calc_out[j*2*DW +: 2*DW];
      end
    end
  end

  // X[k] is stored at address (k mod 4)*4 + k/4.
  assign out_index = out_cnt;
  assign out_data  = bank[{out_cnt[1:0], out_cnt[3:2]}];

endmodule

// File: tb/tb_fft_bf_sched.sv
module tb_fft_bf_sched;
  localparam int DW = 17;
`ifdef BF_PIPE_EN
  localparam int OPSTEP = 2;
  localparam int OPOFF  = 1;
`else
  localparam int OPSTEP = 1;
  localparam int OPOFF  = 0;
`endif
  localparam int CALC_CYC = 8 * OPSTEP;
  localparam int RST_AT   = 3 * OPSTEP;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [2*DW-1:0] in_data, out_data;
  logic [8*DW-1:0] bf_calc_in, bf_calc_out;
  logic [2:0]      bf_rotation;
  logic [3:0]      out_index;
  bit              stub_add;

  always #5 clk = ~clk;

  fft_bf_sched #(.DW(DW), .NPT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .bf_calc_in(bf_calc_in), .bf_rotation(bf_rotation), .bf_calc_out(bf_calc_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .busy(busy), .done(done)
  );

  // Butterfly stub: pass-through, optionally +1 on every real part.
  always_comb begin
    bf_calc_out = bf_calc_in;
    if (stub_add)
      for (int i = 0; i < 4; i++)
        bf_calc_out[i*2*DW+DW +: DW] = bf_calc_in[i*2*DW+DW +: DW] + DW'(1);
  end

  int checks = 0;
  int passes = 0;

  logic [2*DW-1:0] x_in [16];
  logic [2*DW-1:0] exp_out [16];
  logic [8*DW-1:0] exp_cin [8];
  int ramp_re [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

  logic [2*DW-1:0] obs_out [16];
  logic [3:0]      obs_idx [16];
  logic [2:0]      obs_rot [32];
  logic [8*DW-1:0] obs_cin [32];
  int n_out, n_calc, first_ready_cyc, first_valid_cyc, last_calc_cyc;
  int done_cnt, done_cyc, last_hs_cyc, stall_bad, done_busy_bad, idle_bf_bad, extra_bad;
  bit timeout;

  // Reference: the butterfly schedule applied to a plain array.
  task automatic build_model();
    logic [2*DW-1:0] m [16];
    int a [4];
    m = x_in;
    for (int op = 0; op < 8; op++) begin
      for (int j = 0; j < 4; j++) begin
        a[j] = (op < 4) ? op + 4*j : 4*(op-4) + j;
        exp_cin[op][j*2*DW +: 2*DW] = m[a[j]];
      end
      for (int j = 0; j < 4; j++)
        if (stub_add) m[a[j]][2*DW-1:DW] = m[a[j]][2*DW-1:DW] + DW'(1);
    end
    for (int k = 0; k < 16; k++) exp_out[k] = m[(k%4)*4 + k/4];
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 16; i++) x_in[i] = {DW'(i), DW'(0)};
  endtask

  task automatic fill_random();
    logic [63:0] r;
    for (int i = 0; i < 16; i++) begin
      r = {$urandom, $urandom};
      x_in[i] = r[2*DW-1:0];
    end
  endtask

  // Runs one transform and records what the DUT did; the test tasks judge.
  task automatic xfer(input int gap_mode, input int omode, input bit chain, input bit skip_start);
    int cyc = 0, ld_i = 0, hold_cnt = 0;
    bit tog = 0, was_stalled = 0, got_done = 0;
    logic [63:0] r;
    logic [2*DW-1:0] pd = '0;
    logic [3:0] pi = '0;
    n_out = 0; n_calc = 0; first_ready_cyc = -1; first_valid_cyc = -1;
    last_calc_cyc = -1; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
    stall_bad = 0; done_busy_bad = 0; idle_bf_bad = 0; extra_bad = 0; timeout = 0;
    if (!skip_start) begin @(negedge clk); start = 1'b1; end
    @(posedge clk);
    while (!got_done && cyc < 800) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (in_ready && first_ready_cyc < 0) first_ready_cyc = cyc;
      if (busy && !in_ready && !out_valid) begin
        if (n_calc < 32) begin obs_rot[n_calc] = bf_rotation; obs_cin[n_calc] = bf_calc_in; end
        n_calc++;
        last_calc_cyc = cyc;
      end else if (bf_rotation !== 3'd0 || bf_calc_in !== '0) idle_bf_bad++;
      r = {$urandom, $urandom};
      if (in_ready) begin
        in_valid = (gap_mode == 0) || ($urandom_range(0, 2) != 0);
        in_data  = (in_valid && ld_i < 16) ? x_in[ld_i & 15] : r[2*DW-1:0];
        if (in_valid) ld_i++;
      end else begin
        in_valid = r[40];
        in_data  = r[2*DW-1:0];
      end
      if (out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (was_stalled && (out_data !== pd || out_index !== pi)) stall_bad++;
      end
      case (omode)
        0: out_ready = 1'b1;
        1: if (out_valid && n_out == 7 && hold_cnt < 5) begin
             out_ready = 1'b0;
             hold_cnt++;
           end else begin
             tog = !tog;
             out_ready = tog;
           end
        default: out_ready = r[41];
      endcase
      was_stalled = out_valid && !out_ready;
      pd = out_data;
      pi = out_index;
      if (out_valid && out_ready) begin
        if (n_out < 16) begin obs_out[n_out] = out_data; obs_idx[n_out] = out_index; end
        n_out++;
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        got_done = 1;
        if (busy) done_busy_bad++;
        if (chain) start = 1'b1;
      end
    end
    if (!got_done) timeout = 1;
    if (!chain)
      repeat (4) begin
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        if (done || out_valid || busy) extra_bad++;
      end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0; stub_add = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passes++;
    checks++; if (bf_rotation !== 3'd0) $display("FAIL reset_rot got %0d want 0", bf_rotation); else passes++;
    checks++; if (bf_calc_in !== '0) $display("FAIL reset_calc_in got %0h want 0", bf_calc_in); else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    logic [8*DW-1:0] c;
    fill_ramp();
    stub_add = 0;
    xfer(0, 0, 0, 0);
    checks++; if (timeout) $display("FAIL ramp_timeout got no done want done"); else passes++;
    checks++; if (first_ready_cyc !== 1) $display("FAIL ramp_start_latency got %0d want 1", first_ready_cyc); else passes++;
    checks++; if (n_calc !== CALC_CYC) $display("FAIL ramp_calc_len got %0d want %0d", n_calc, CALC_CYC); else passes++;
    checks++; if (first_valid_cyc !== last_calc_cyc + 1) $display("FAIL ramp_first_valid got %0d want %0d", first_valid_cyc, last_calc_cyc + 1); else passes++;
    for (int op = 0; op < 8; op++) begin
      checks++;
      if (obs_rot[op*OPSTEP+OPOFF] !== 3'(op)) $display("FAIL ramp_rotation op%0d got %0d want %0d", op, obs_rot[op*OPSTEP+OPOFF], op); else passes++;
    end
`ifdef BF_PIPE_EN
    for (int op = 0; op < 7; op++) begin
      checks++;
      if (obs_rot[op*2+2] !== 3'(op)) $display("FAIL ramp_rotation_hold op%0d got %0d want %0d", op, obs_rot[op*2+2], op); else passes++;
    end
`else
    checks++; if (idle_bf_bad !== 0) $display("FAIL ramp_bf_idle_zero got %0d nonzero cycles want 0", idle_bf_bad); else passes++;
`endif
    for (int j = 0; j < 4; j++) begin
      c = obs_cin[2*OPSTEP+OPOFF];
      checks++; if (c[j*2*DW+DW +: DW] !== DW'(2 + 4*j)) $display("FAIL ramp_op2_in%0d got %0d want %0d", j+1, c[j*2*DW+DW +: DW], 2 + 4*j); else passes++;
      c = obs_cin[5*OPSTEP+OPOFF];
      checks++; if (c[j*2*DW+DW +: DW] !== DW'(4 + j)) $display("FAIL ramp_op5_in%0d got %0d want %0d", j+1, c[j*2*DW+DW +: DW], 4 + j); else passes++;
    end
    checks++; if (n_out !== 16) $display("FAIL ramp_count got %0d want 16", n_out); else passes++;
    for (int k = 0; k < 16; k++) begin
      checks++; if (obs_out[k] !== {DW'(ramp_re[k]), DW'(0)}) $display("FAIL ramp_X%0d got %0h want Re=%0d Im=0", k, obs_out[k], ramp_re[k]); else passes++;
      checks++; if (obs_idx[k] !== 4'(k)) $display("FAIL ramp_index%0d got %0d want %0d", k, obs_idx[k], k); else passes++;
    end
    checks++; if (done_cnt !== 1) $display("FAIL ramp_done_count got %0d want 1", done_cnt); else passes++;
    checks++; if (done_cyc !== last_hs_cyc + 1) $display("FAIL ramp_done_timing got %0d want %0d", done_cyc, last_hs_cyc + 1); else passes++;
    checks++; if (done_busy_bad !== 0) $display("FAIL ramp_busy_at_done got %0d want 0", done_busy_bad); else passes++;
    checks++; if (extra_bad !== 0) $display("FAIL ramp_idle_after got %0d want 0", extra_bad); else passes++;
  endtask

  task automatic test_random_add();
    logic [2*DW-1:0] src;
    for (int it = 0; it < 3; it++) begin
      fill_random();
      stub_add = 1;
      build_model();
      xfer(1, 2, 0, 0);
      stub_add = 0;
      checks++; if (timeout || n_out !== 16) $display("FAIL add_count got %0d want 16", n_out); else passes++;
      for (int op = 0; op < 8; op++) begin
        checks++; if (obs_cin[op*OPSTEP+OPOFF] !== exp_cin[op]) $display("FAIL add_calc_in op%0d got %0h want %0h", op, obs_cin[op*OPSTEP+OPOFF], exp_cin[op]); else passes++;
      end
      for (int k = 0; k < 16; k++) begin
        src = x_in[(k%4)*4 + k/4];
        checks++; if (obs_out[k] !== exp_out[k]) $display("FAIL add_X%0d got %0h want %0h", k, obs_out[k], exp_out[k]); else passes++;
        checks++; if (obs_out[k][2*DW-1:DW] !== src[2*DW-1:DW] + DW'(2)) $display("FAIL add_re_plus2 k%0d got %0h want %0h", k, obs_out[k][2*DW-1:DW], src[2*DW-1:DW] + DW'(2)); else passes++;
      end
      checks++; if (done_cnt !== 1) $display("FAIL add_done_count got %0d want 1", done_cnt); else passes++;
    end
  endtask

  task automatic test_backpressure();
    fill_random();
    stub_add = 0;
    build_model();
    xfer(1, 1, 0, 0);
    checks++; if (timeout || n_out !== 16) $display("FAIL bp_count got %0d want 16", n_out); else passes++;
    checks++; if (stall_bad !== 0) $display("FAIL bp_stable got %0d changes want 0", stall_bad); else passes++;
    for (int k = 0; k < 16; k++) begin
      checks++; if (obs_out[k] !== exp_out[k] || obs_idx[k] !== 4'(k)) $display("FAIL bp_X%0d got %0h idx %0d want %0h idx %0d", k, obs_out[k], obs_idx[k], exp_out[k], k); else passes++;
    end
    checks++; if (done_cnt !== 1 || extra_bad !== 0) $display("FAIL bp_done got %0d extra %0d want 1 extra 0", done_cnt, extra_bad); else passes++;
  endtask

  task automatic test_back_to_back();
    fill_random();
    build_model();
    xfer(0, 0, 1, 0);
    checks++; if (timeout || n_out !== 16) $display("FAIL b2b_first_count got %0d want 16", n_out); else passes++;
    for (int k = 0; k < 16; k++) begin
      checks++; if (obs_out[k] !== exp_out[k]) $display("FAIL b2b_first_X%0d got %0h want %0h", k, obs_out[k], exp_out[k]); else passes++;
    end
    fill_random();
    build_model();
    xfer(0, 2, 0, 1);
    checks++; if (first_ready_cyc !== 1) $display("FAIL b2b_restart got %0d want 1", first_ready_cyc); else passes++;
    checks++; if (timeout || n_out !== 16) $display("FAIL b2b_second_count got %0d want 16", n_out); else passes++;
    for (int k = 0; k < 16; k++) begin
      checks++; if (obs_out[k] !== exp_out[k]) $display("FAIL b2b_second_X%0d got %0h want %0h", k, obs_out[k], exp_out[k]); else passes++;
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0, ld_i = 0, nc = 0, bad = 0;
    bit fired = 0;
    fill_ramp();
    stub_add = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    while (!fired && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (in_ready) begin in_valid = 1'b1; in_data = x_in[ld_i & 15]; ld_i++; end
      else in_valid = 1'b0;
      out_ready = 1'b1;
      if (busy && !in_ready && !out_valid) begin
        if (nc == RST_AT) begin rst_n = 1'b0; fired = 1; end
        nc++;
      end
    end
    checks++; if (!fired) $display("FAIL rstmid_reach_calc got no CALC want CALC"); else passes++;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0)
      $display("FAIL rstmid_idle got busy=%b ov=%b ir=%b done=%b want all 0", busy, out_valid, in_ready, done);
    else passes++;
    repeat (20) begin
      @(negedge clk);
      if (done || out_valid || busy) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL rstmid_quiet got %0d active cycles want 0", bad); else passes++;
    xfer(0, 0, 0, 0);
    checks++; if (timeout || n_out !== 16 || done_cnt !== 1) $display("FAIL rstmid_rerun got %0d outputs %0d done want 16 1", n_out, done_cnt); else passes++;
    for (int k = 0; k < 16; k++) begin
      checks++; if (obs_out[k] !== {DW'(ramp_re[k]), DW'(0)}) $display("FAIL rstmid_X%0d got %0h want Re=%0d", k, obs_out[k], ramp_re[k]); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_random_add();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
